// File: rtl/window_fetcher_ext.sv
// Sliding-window fetcher: streams raster pixels through line buffers and emits one
// WINDOW_HEIGHT x WINDOW_WIDTH neighbourhood per pixel, with constant/replicate borders.
module window_fetcher_ext #(
  parameter int unsigned DATA_WIDTH                  = 16,
  parameter int unsigned CHANNELS                    = 1,
  parameter int unsigned MAX_IMAGE_WIDTH             = 1024,
  parameter int unsigned MAX_IMAGE_HEIGHT            = 1024,
  parameter int unsigned WINDOW_WIDTH                = 3,
  parameter int unsigned WINDOW_HEIGHT               = 3,
  parameter int          WINDOW_WIDTH_CENTER_OFFSET  = 0,
  parameter int          WINDOW_HEIGHT_CENTER_OFFSET = 0,
  parameter int unsigned BORDER_MODE                 = 0,
  parameter logic [CHANNELS*DATA_WIDTH-1:0] BORDER_EXTENSION_CONSTANT = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [15:0]                    img_width_i,
  input  logic [15:0]                    img_height_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic [CHANNELS*DATA_WIDTH-1:0] window_o [WINDOW_HEIGHT][WINDOW_WIDTH],
  output logic [15:0]                    col_o,
  output logic [15:0]                    row_o,
  output logic                           sof_o,
  output logic                           eof_o,
  output logic                           valid_o,
  input  logic                           ready_i
);

  localparam int unsigned PW        = CHANNELS * DATA_WIDTH;
  localparam int          WC        = (int'(WINDOW_WIDTH) - 1) / 2 + WINDOW_WIDTH_CENTER_OFFSET;
  localparam int          HC        = (int'(WINDOW_HEIGHT) - 1) / 2 + WINDOW_HEIGHT_CENTER_OFFSET;
  localparam int unsigned LEAD_ROWS = unsigned'(int'(WINDOW_HEIGHT) - 1 - HC);
  localparam int unsigned LEAD_COLS = unsigned'(int'(WINDOW_WIDTH) - 1 - WC);
  localparam int unsigned LEAD_MAX  = LEAD_ROWS * MAX_IMAGE_WIDTH + LEAD_COLS;
  localparam int unsigned LW        = $clog2(LEAD_MAX + 1) + 1;
  localparam int unsigned AW        = (MAX_IMAGE_WIDTH > 1) ? $clog2(MAX_IMAGE_WIDTH) : 1;
  localparam int unsigned LB_N      = (WINDOW_HEIGHT > 1) ? WINDOW_HEIGHT - 1 : 1;
  localparam int unsigned RIW       = (WINDOW_HEIGHT > 1) ? $clog2(WINDOW_HEIGHT) : 1;
  localparam int unsigned CIW       = (WINDOW_WIDTH > 1) ? $clog2(WINDOW_WIDTH) : 1;
  localparam logic [15:0] W_MIN     = 16'(WINDOW_WIDTH);
  localparam logic [15:0] W_MAX     = 16'(MAX_IMAGE_WIDTH);
  localparam logic [15:0] H_MIN     = 16'(WINDOW_HEIGHT);
  localparam logic [15:0] H_MAX     = 16'(MAX_IMAGE_HEIGHT);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [15:0]     w_q, h_q, w_clamp, h_clamp, w_eff, h_eff;
  logic [LW-1:0]   lead_q, lead_c, lead_eff, adv_q;
  logic [15:0]     in_col_q, in_row_q, cen_col_q, cen_row_q;
  logic [AW-1:0]   addr_q;
  logic            done_q;
  logic            accept, flush_adv, advance, emit, in_last, cen_last, frame_done;
  logic [PW-1:0]   pix_in;
  logic [PW-1:0]   raw_q [WINDOW_HEIGHT][WINDOW_WIDTH];
  logic [PW-1:0]   raw_n [WINDOW_HEIGHT][WINDOW_WIDTH];
  logic [PW-1:0]   win_n [WINDOW_HEIGHT][WINDOW_WIDTH];
  logic [PW-1:0]   lb    [LB_N][MAX_IMAGE_WIDTH];
  logic [PW-1:0]   lb_rd [LB_N];
  logic            row_bord [WINDOW_HEIGHT];
  logic            col_bord [WINDOW_WIDTH];
  logic [RIW-1:0]  rsel [WINDOW_HEIGHT];
  logic [CIW-1:0]  csel [WINDOW_WIDTH];

  // Frame geometry: live inputs on the first pixel, latched values afterwards.
  always_comb begin
    w_clamp  = (img_width_i < W_MIN) ? W_MIN : ((img_width_i > W_MAX) ? W_MAX : img_width_i);
    h_clamp  = (img_height_i < H_MIN) ? H_MIN : ((img_height_i > H_MAX) ? H_MAX : img_height_i);
    lead_c   = LW'(LEAD_ROWS * 32'(w_clamp) + LEAD_COLS);
    w_eff    = (state_q == IDLE) ? w_clamp : w_q;
    h_eff    = (state_q == IDLE) ? h_clamp : h_q;
    lead_eff = (state_q == IDLE) ? lead_c : lead_q;
  end

  assign ready_o    = (state_q != FLUSH) && (!valid_o || ready_i);
  assign accept     = valid_i && ready_o;
  assign flush_adv  = (state_q == FLUSH) && (!valid_o || ready_i) && !done_q;
  assign advance    = accept || flush_adv;
  assign pix_in     = accept ? data_i : '0;
  assign emit       = advance && (adv_q >= lead_eff);
  assign in_last    = (in_col_q == w_eff - 16'd1) && (in_row_q == h_eff - 16'd1);
  assign cen_last   = (cen_col_q == w_eff - 16'd1) && (cen_row_q == h_eff - 16'd1);
  assign frame_done = (state_q == FLUSH) && valid_o && ready_i && eof_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? FLUSH : RUN;
      RUN:     if (accept && in_last) state_d = FLUSH;
      FLUSH:   if (frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window shifts left; the new right column comes from the line buffers plus the input.
  always_comb begin
    for (int i = 0; i < int'(LB_N); i++) lb_rd[i] = lb[i][addr_q];
    for (int r = 0; r < int'(WINDOW_HEIGHT); r++) begin
      for (int c = 0; c < int'(WINDOW_WIDTH) - 1; c++) raw_n[r][c] = raw_q[r][c+1];
    end
    for (int r = 0; r < int'(WINDOW_HEIGHT) - 1; r++)
      raw_n[r][WINDOW_WIDTH-1] = lb_rd[int'(WINDOW_HEIGHT) - 2 - r];
    raw_n[WINDOW_HEIGHT-1][WINDOW_WIDTH-1] = pix_in;
  end

  // Border detection in signed coordinates; replicate picks the clamped in-window element.
  always_comb begin
    logic signed [16:0] ir, ic, h_max, w_max;
    h_max = $signed({1'b0, h_eff - 16'd1});
    w_max = $signed({1'b0, w_eff - 16'd1});
    ir = '0;
    ic = '0;
    for (int r = 0; r < int'(WINDOW_HEIGHT); r++) begin
      ir = $signed({1'b0, cen_row_q}) + 17'(r - HC);
      row_bord[r] = (ir < 0) || (ir > h_max);
      if (ir < 0)          rsel[r] = RIW'(r - int'(ir));
      else if (ir > h_max) rsel[r] = RIW'(r - int'(ir - h_max));
      else                 rsel[r] = RIW'(r);
    end
    for (int c = 0; c < int'(WINDOW_WIDTH); c++) begin
      ic = $signed({1'b0, cen_col_q}) + 17'(c - WC);
      col_bord[c] = (ic < 0) || (ic > w_max);
      if (ic < 0)          csel[c] = CIW'(c - int'(ic));
      else if (ic > w_max) csel[c] = CIW'(c - int'(ic - w_max));
      else                 csel[c] = CIW'(c);
    end
    for (int r = 0; r < int'(WINDOW_HEIGHT); r++) begin
      for (int c = 0; c < int'(WINDOW_WIDTH); c++) begin
        if (BORDER_MODE == 1)
          win_n[r][c] = raw_n[rsel[r]][csel[c]];
        else
          win_n[r][c] = (row_bord[r] || col_bord[c]) ? BORDER_EXTENSION_CONSTANT : raw_n[r][c];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_q       <= '0;
      h_q       <= '0;
      lead_q    <= '0;
      adv_q     <= '0;
      in_col_q  <= '0;
      in_row_q  <= '0;
      cen_col_q <= '0;
      cen_row_q <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      valid_o   <= 1'b0;
      sof_o     <= 1'b0;
      eof_o     <= 1'b0;
      col_o     <= '0;
      row_o     <= '0;
      for (int r = 0; r < int'(WINDOW_HEIGHT); r++) begin
        for (int c = 0; c < int'(WINDOW_WIDTH); c++) begin
          raw_q[r][c]    <= '0;
          window_o[r][c] <= '0;
        end
      end
    end else begin
      if ((state_q == IDLE) && accept) begin
        w_q    <= w_clamp;
        h_q    <= h_clamp;
        lead_q <= lead_c;
      end
      if (advance) begin
        raw_q  <= raw_n;
        addr_q <= (addr_q == AW'(w_eff - 16'd1)) ? '0 : addr_q + AW'(1);
        if (adv_q < lead_eff) adv_q <= adv_q + LW'(1);
      end
      if (accept) begin
        if (in_col_q == w_eff - 16'd1) begin
          in_col_q <= '0;
          in_row_q <= in_row_q + 16'd1;
        end else begin
          in_col_q <= in_col_q + 16'd1;
        end
      end
      if (emit) begin
        window_o <= win_n;
        col_o    <= cen_col_q;
        row_o    <= cen_row_q;
        sof_o    <= (cen_col_q == 16'd0) && (cen_row_q == 16'd0);
        eof_o    <= cen_last;
        valid_o  <= 1'b1;
        done_q   <= cen_last;
        if (cen_col_q == w_eff - 16'd1) begin
          cen_col_q <= '0;
          cen_row_q <= cen_row_q + 16'd1;
        end else begin
          cen_col_q <= cen_col_q + 16'd1;
        end
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
      // Last output taken: rearm per-frame counters for the next frame.
      if (frame_done) begin
        adv_q     <= '0;
        in_col_q  <= '0;
        in_row_q  <= '0;
        cen_col_q <= '0;
        cen_row_q <= '0;
        addr_q    <= '0;
        done_q    <= 1'b0;
      end
    end
  end

  // Line-buffer storage has no reset; stale entries are masked as border.
  always_ff @(posedge clk_i) begin
    if (advance && (WINDOW_HEIGHT > 1)) begin
      lb[0][addr_q] <= pix_in;
      for (int i = 1; i < int'(LB_N); i++) lb[i][addr_q] <= lb_rd[i-1];
    end
  end

endmodule

// File: tb/tb_window_fetcher_ext.sv
// Scoreboard bench: constant-border and replicate-border instances share one stimulus.
module tb_window_fetcher_ext;

  typedef struct packed {
    logic [15:0]  row;
    logic [15:0]  col;
    logic         sof;
    logic         eof;
    logic [143:0] wc;
    logic [143:0] wr;
    logic [31:0]  exp_acc;
    logic [1:0]   tag;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] img_width_i, img_height_i, data_i;
  logic        valid_i, ready_i;

  logic        c_ready, c_sof, c_eof, c_valid;
  logic        r_ready, r_sof, r_eof, r_valid;
  logic [15:0] c_col, c_row, r_col, r_row;
  logic [15:0] c_win [3][3];
  logic [15:0] r_win [3][3];
  logic [143:0] c_flat, r_flat;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;
  int   acc_cnt = 0;
  int   first_wait;

  always #5 clk_i = ~clk_i;

  window_fetcher_ext #(.BORDER_MODE(0)) u_const (
    .clk_i(clk_i), .rst_i(rst_i), .img_width_i(img_width_i), .img_height_i(img_height_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(c_ready), .window_o(c_win),
    .col_o(c_col), .row_o(c_row), .sof_o(c_sof), .eof_o(c_eof), .valid_o(c_valid),
    .ready_i(ready_i));

  window_fetcher_ext #(.BORDER_MODE(1)) u_repl (
    .clk_i(clk_i), .rst_i(rst_i), .img_width_i(img_width_i), .img_height_i(img_height_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(r_ready), .window_o(r_win),
    .col_o(r_col), .row_o(r_row), .sof_o(r_sof), .eof_o(r_eof), .valid_o(r_valid),
    .ready_i(ready_i));

  always_comb begin
    c_flat = '0;
    r_flat = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        c_flat[(r*3+c)*16 +: 16] = c_win[r][c];
        r_flat[(r*3+c)*16 +: 16] = r_win[r][c];
      end
    end
  end

  task automatic chk(input string name, input logic [143:0] got, input logic [143:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [143:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {16'(a8), 16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // Reference window straight from the image definition and border rule.
  function automatic logic [143:0] model_win(input int w, h, base, cr, cc, input bit rep);
    logic [143:0] v;
    int ir, ic, px;
    v = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        ir = cr + r - 1;
        ic = cc + c - 1;
        if (ir >= 0 && ir < h && ic >= 0 && ic < w) px = base + ir * w + ic;
        else if (rep) begin
          if (ir < 0) ir = 0;
          if (ir > h - 1) ir = h - 1;
          if (ic < 0) ic = 0;
          if (ic > w - 1) ic = w - 1;
          px = base + ir * w + ic;
        end else px = 0;
        v[(r*3+c)*16 +: 16] = 16'(px);
      end
    end
    return v;
  endfunction

  // Monitor: pop and compare on every output handshake, then count input accepts.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (c_valid && ready_i) begin
        if (q.size() == 0) chk("unexpected_output", {c_row, c_col}, '1);
        else begin
          e = q.pop_front();
          chk("row", c_row, e.row);
          chk("col", c_col, e.col);
          chk("sof", c_sof, e.sof);
          chk("eof", c_eof, e.eof);
          chk("win_const", c_flat, e.wc);
          chk("win_repl", r_flat, e.wr);
          chk("repl_sync", {r_valid, r_row, r_col, r_sof, r_eof}, {1'b1, e.row, e.col, e.sof, e.eof});
          if (e.sof) chk("first_latency", acc_cnt, e.exp_acc);
          if (e.tag == 2'd1 && e.row == 16'd0 && e.col == 16'd0) begin
            chk("hand_const_00", c_flat, pk(0, 0, 0, 0, 0, 1, 0, 4, 5));
            chk("hand_repl_00", r_flat, pk(0, 0, 1, 0, 0, 1, 4, 4, 5));
          end
          if (e.tag == 2'd1 && e.row == 16'd3 && e.col == 16'd3) begin
            chk("hand_repl_33", r_flat, pk(10, 11, 11, 14, 15, 15, 14, 15, 15));
            chk("hand_const_33", c_flat, pk(10, 11, 0, 14, 15, 0, 0, 0, 0));
            chk("hand_eof_33", c_eof, 1'b1);
          end
        end
      end
      if (valid_i && c_ready) acc_cnt++;
    end
  end

  task automatic send_pix(input logic [15:0] d, output int waited);
    int  n;
    logic got;
    n = 0;
    got = 1'b0;
    waited = 0;
    valid_i = 1'b1;
    data_i = d;
    while (!got && n < 100) begin
      @(negedge clk_i);
      got = c_ready;
      if (!got) waited++;
      n++;
      @(posedge clk_i);
      #1;
    end
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic do_stall();
    logic [143:0] sc;
    logic [36:0]  sm;
    int a0;
    chk("stall_precond_valid", c_valid, 1'b1);
    ready_i = 1'b0;
    a0 = acc_cnt;
    sc = c_flat;
    sm = {c_row, c_col, c_sof, c_eof, c_valid, 3'b0};
    repeat (5) begin
      @(negedge clk_i);
      chk("stall_hold_win", c_flat, sc);
      chk("stall_hold_ctrl", {c_row, c_col, c_sof, c_eof, c_valid, 3'b0}, sm);
      chk("stall_ready_o", c_ready, 1'b0);
    end
    chk("stall_no_accept", acc_cnt, a0);
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
  endtask

  task automatic send_frame(input int w, h, base, npix, stall_at, tag, output int wait0);
    exp_t x;
    int   wt;
    wait0 = 0;
    img_width_i = 16'(w);
    img_height_i = 16'(h);
    for (int i = 0; i < w * h; i++) begin
      x.row = 16'(i / w);
      x.col = 16'(i % w);
      x.sof = (i == 0);
      x.eof = (i == w * h - 1);
      x.wc = model_win(w, h, base, i / w, i % w, 1'b0);
      x.wr = model_win(w, h, base, i / w, i % w, 1'b1);
      x.exp_acc = 32'(acc_cnt + w + 2);
      x.tag = 2'(tag);
      q.push_back(x);
    end
    for (int i = 0; i < npix; i++) begin
      if (i == stall_at) begin
        valid_i = 1'b1;
        data_i = 16'(base + i);
        do_stall();
      end
      send_pix(16'(base + i), wt);
      if (i == 0) wait0 = wt;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk_i);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (4) @(posedge clk_i);
    #1;
    chk("idle_valid", c_valid, 1'b0);
    chk("idle_ready", c_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i = '0;
    img_width_i = 16'd4;
    img_height_i = 16'd4;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", c_valid, 1'b0);
    chk("rst_win", c_flat, '0);
    chk("rst_ctrl", {c_row, c_col, c_sof, c_eof}, '0);
    rst_i = 1'b0;
    #1;
    chk("rst_ready", c_ready, 1'b1);

    // 4x4 frame, drained by flush.
    send_frame(4, 4, 0, 16, -1, 1, first_wait);
    valid_i = 1'b0;
    drain();

    // 4x4 frame with a downstream stall, then a 5x3 frame queued behind its flush.
    send_frame(4, 4, 0, 16, 10, 1, first_wait);
    send_frame(5, 3, 100, 15, -1, 2, first_wait);
    chk("b_stalled_min", 32'(first_wait >= 5), 1);
    chk("b_stalled_max", 32'(first_wait <= 8), 1);
    valid_i = 1'b0;
    drain();

    // Reset while output 7 is presented; the frame is abandoned.
    send_frame(4, 4, 0, 12, -1, 1, first_wait);
    chk("rst_mid_precond", {c_valid, c_row, c_col}, {1'b1, 16'd1, 16'd2});
    rst_i = 1'b1;
    valid_i = 1'b0;
    #1;
    chk("rst_mid_valid", c_valid, 1'b0);
    chk("rst_mid_ctrl", {c_row, c_col, c_sof, c_eof}, '0);
    q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rst_mid_ready", c_ready, 1'b1);

    // Fresh frame after reset.
    send_frame(4, 4, 0, 16, -1, 1, first_wait);
    valid_i = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
